// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_pkg
//  Description : Shared definitions for the instruction fetch unit: fetch FSM
//                state encoding, PC increment, default reset PC and the MIPS
//                opcode constants that decode/control also use.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

  // Fetch FSM state encoding (explicit 2-bit width).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // out of reset, about to issue the first request
    ST_REQ   = 2'd1,  // request outstanding at pc
    ST_HOLD  = 2'd2,  // instruction presented to decode, waiting for ready
    ST_DRAIN = 2'd3   // redirected while a request was in flight; swallow the ack
  } fetch_state_e;

  localparam int          PC_INCR          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // MIPS primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

endpackage : instr_fetch_unit_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_if
//  Description : Bundles the instruction-memory req/ack bus, the decode
//                valid/ready channel and the execute-stage redirect.
//                master : the fetch unit
//                slave  : the environment (memory, decode, execute)
//  Ports       : none (signals only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  // Instruction memory side
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  // Decode side
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  // Execute-stage branch redirect
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

endinterface : instr_fetch_if
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc_reg
//  Description : Program counter and deferred redirect target (pc_next).
//                Operations, highest priority first, for pc:
//                  load_target : pc <= word-aligned redirect target
//                  load_stash  : pc <= pc_next
//                  incr        : pc <= pc + 4 (wraps modulo 2^ADDR_W)
//                stash_target : pc_next <= word-aligned redirect target
//  Ports       : clk, rst (async, active high), operation strobes,
//                target_raw (unaligned redirect target), pc (current PC)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              load_target,
  input  wire logic              stash_target,
  input  wire logic              load_stash,
  input  wire logic              incr,
  input  wire logic [ADDR_W-1:0] target_raw,
  output logic      [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_d,      pc_q;
  logic [ADDR_W-1:0] pc_next_d, pc_next_q;

  // Low two bits of the redirect target are ignored.
  assign target = target_raw & ALIGN_MASK;

  always_comb begin
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    if (load_target)     pc_d = target;
    else if (load_stash) pc_d = pc_next_q;
    else if (incr)       pc_d = pc_q + ADDR_W'(PC_INCR);
    if (stash_target)    pc_next_d = target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC;
    end else begin
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
    end
  end

  assign pc = pc_q;

endmodule : fetch_pc_reg
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction supply for the single-cycle MIPS datapath.
//                Requests words from instruction memory at pc, presents each
//                fetched word to decode with valid/ready, and follows branch
//                redirects from execute with highest priority.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - instr_fetch_if.master (imem req/addr/ack/rdata,
//                       instr/instr_pc/instr_valid/instr_ready,
//                       redirect/redirect_pc)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input wire logic       clk,
  input wire logic       rst,
  instr_fetch_if.master  bus
);

  fetch_state_e      state_d,    state_q;
  logic [DATA_W-1:0] instr_d,    instr_q;
  logic [ADDR_W-1:0] instr_pc_d, instr_pc_q;

  logic              pc_load_target;
  logic              pc_stash_target;
  logic              pc_load_stash;
  logic              pc_incr;
  logic [ADDR_W-1:0] pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .load_target  (pc_load_target),
    .stash_target (pc_stash_target),
    .load_stash   (pc_load_stash),
    .incr         (pc_incr),
    .target_raw   (bus.redirect_pc),
    .pc           (pc)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    instr_pc_d      = instr_pc_q;
    pc_load_target  = 1'b0;
    pc_stash_target = 1'b0;
    pc_load_stash   = 1'b0;
    pc_incr         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.redirect) pc_load_target = 1'b1;
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (bus.redirect) begin
          if (bus.imem_ack) begin
            // Returned word belongs to the wrong path: drop it, refetch at target.
            pc_load_target = 1'b1;
          end else begin
            // Address must stay put until the memory answers; park the target.
            pc_stash_target = 1'b1;
            state_d         = ST_DRAIN;
          end
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc;
          pc_incr    = 1'b1;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // A redirect squashes the presented word even if decode takes it now.
        if (bus.redirect) begin
          pc_load_target = 1'b1;
          state_d        = ST_REQ;
        end else if (bus.instr_ready) begin
          state_d = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (bus.imem_ack) begin
          // Latest redirect wins, including one arriving with the ack.
          if (bus.redirect) pc_load_target = 1'b1;
          else              pc_load_stash  = 1'b1;
          state_d = ST_REQ;
        end else if (bus.redirect) begin
          pc_stash_target = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Request and valid come straight from the state register, so an async
  // reset drops them immediately.
  assign bus.imem_req    = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state_q == ST_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule : instr_fetch_unit
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-supply side of the single-cycle MIPS datapath.
- Owns the PC, requests words from instruction memory over a req/ack handshake, and presents each fetched instruction to decode (control, alu_control) with valid/ready.
- Accepts a branch redirect from the execute stage, computed from branch & zero.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, PC value after reset (word-aligned)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  ADDR_W  fetch address; stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  DATA_W  fetched word, valid when imem_ack=1
instr  output  DATA_W  instruction to decode (instr[31:26] opcode, instr[5:0] funct)
instr_pc  output  ADDR_W  address of the presented instr
instr_valid  output  1  instr/instr_pc are valid
instr_ready  input  1  decode consumes instr when instr_valid & instr_ready
redirect  input  1  taken-branch redirect, single-cycle pulse
redirect_pc  input  ADDR_W  redirect target; bits [1:0] ignored (forced 00)

Behaviour:
- All outputs are registered or decoded directly from the state register.
- FSM states: IDLE, REQ, HOLD, DRAIN.
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0.
- Output decode: imem_req = (state==REQ or DRAIN); imem_addr = pc register (in DRAIN, the held old address).
- IDLE: next edge -> REQ. imem_req rises on the first edge after rst deasserts.
- REQ, imem_ack=1, no redirect:
  - instr<=imem_rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1 -> HOLD.
  - Minimum latency: ack in cycle N gives instr_valid in cycle N+1.
- REQ, imem_ack=0: stay. Address must not change.
- HOLD: instr_valid=1; instr and instr_pc are stable until the handshake.
  - On instr_valid & instr_ready: instr_valid<=0 -> REQ.
  - Peak throughput is one instruction per 2 cycles.
- Redirect has the highest priority, always. Effective target = {redirect_pc[ADDR_W-1:2],2'b00}.
  - IDLE or HOLD: pc<=target, instr_valid<=0 (presented instr is squashed even if instr_ready=1) -> REQ.
  - REQ with imem_ack=1 same cycle: discard rdata, pc<=target, stay REQ. The next request uses target.
  - REQ with imem_ack=0: the request is outstanding. pc_next<=target -> DRAIN. Keep req high on the old address until ack.
  - DRAIN: on ack, discard rdata, load pc<=pc_next -> REQ. A further redirect in DRAIN overwrites pc_next (latest wins).
- imem_ack in IDLE/HOLD: ignored, no state change.
- PC arithmetic is modulo 2^ADDR_W: 32'hFFFF_FFFC+4 = 0, no flag.
- Mid-operation reset: the outstanding request is abandoned (req drops asynchronously). The memory side must tolerate this.

Decomposition:
- Shared package: FSM state encoding (IDLE/REQ/HOLD/DRAIN), PC_INCR=4, default RESET_PC, MIPS opcode constants (R-type 6'h00, ADDI 6'h08, LW 6'h23, SW 6'h2B, BEQ 6'h04). The opcode constants are shared with control.
- One natural sub-module: fetch_pc_reg. It holds pc and pc_next with increment, redirect load and alignment masking. The FSM stays in instr_fetch_unit.

Test Plan:
- Reset release, memory ack same cycle as req with rdata=32'h00000024 -> instr_valid next cycle, instr=32'h00000024, instr_pc=0. Next imem_addr=4 after the ready handshake.
- Ack delayed 3 cycles -> imem_req high and imem_addr constant for 4 cycles. Exactly one instruction is presented.
- Decode holds instr_ready=0 for 5 cycles with instr=32'h8C000020 presented -> instr/instr_pc unchanged, no new imem_req until ready.
- Redirect to 32'h00000103 while in HOLD -> instr_valid drops next cycle, next imem_addr=32'h00000100.
- Redirect to 0x40 during an outstanding req, ack 2 cycles later with 32'hAC000064 -> that word is never presented. Next request address=0x40.
- Assert rst mid-wait -> imem_req and instr_valid drop immediately. After release, first imem_addr=RESET_PC. PC at 32'hFFFFFFFC fetch -> next address 0.
